// File: rtl/nbj_ras_resolver.sv
`default_nettype none
// ============================================================================
// Module      : nbj_ras_resolver
// Description : Next-PC resolver for the non-branch-jump fetch path. Picks the
//               slot addressed by the first jump-table entry, produces the
//               redirect PC and cut position, and maintains a circular return
//               address stack with CALL push, RET pop (underflow fallback to
//               the slot address) and checkpoint/restore for mispredict
//               recovery.
// Ports       : i_clk, i_rst_n              clock / async active-low reset
//               i_valid                     request valid (no backpressure)
//               i_firstJTableEntry          [2:0] type, [10+IDX_W:11] slot idx
//               i_typeAndAddressTableBus    SLOTS x {addr, type}
//               i_seqPc, i_linkPc           fall-through PC / CALL link PC
//               i_restore, i_ckpt           RAS pointer/count restore
//               o_valid, o_nextPc           registered result
//               o_cutPosition               registered slot index
//               o_rasMiss, o_rasOverflow    RET underflow / CALL overwrite
//               o_badIdx                    slot index out of range
//               o_ckpt                      current {count, tos}
// Revision    : 1.0 - initial release
// ============================================================================
module nbj_ras_resolver #(
    parameter  int XLEN      = 32,
    parameter  int SLOTS     = 10,
    parameter  int IDX_W     = 8,
    parameter  int RAS_DEPTH = 8,
    localparam int ENTRY_W   = 3 + XLEN,
    localparam int PTR_W     = $clog2(RAS_DEPTH),
    localparam int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic [10+IDX_W:0]        i_firstJTableEntry,
    input  logic [SLOTS*ENTRY_W-1:0] i_typeAndAddressTableBus,
    input  logic [XLEN-1:0]          i_seqPc,
    input  logic [XLEN-1:0]          i_linkPc,
    input  logic                     i_restore,
    input  logic [PTR_W+CNT_W-1:0]   i_ckpt,
    output logic                     o_valid,
    output logic [XLEN-1:0]          o_nextPc,
    output logic [IDX_W-1:0]         o_cutPosition,
    output logic                     o_rasMiss,
    output logic                     o_rasOverflow,
    output logic                     o_badIdx,
    output logic [PTR_W+CNT_W-1:0]   o_ckpt
);

    localparam logic [2:0]       C_T_B     = 3'd1;
    localparam logic [2:0]       C_T_J     = 3'd2;
    localparam logic [2:0]       C_T_JALR  = 3'd3;
    localparam logic [2:0]       C_T_CALL  = 3'd4;
    localparam logic [2:0]       C_T_RET   = 3'd5;
    localparam logic [IDX_W:0]   C_SLOTS   = (IDX_W+1)'(SLOTS);
    localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(RAS_DEPTH);

    // Stack state
    logic [XLEN-1:0]  r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_tos;
    logic [CNT_W-1:0] r_cnt;

    // Decoded request
    logic [2:0]       w_type;
    logic [IDX_W-1:0] w_idx;
    logic             w_bad;
    logic [XLEN-1:0]  w_slot_addr;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_miss;
    logic             w_ovf;
    logic [XLEN-1:0]  w_next_pc;
    logic [PTR_W-1:0] w_tos_inc;
    logic [PTR_W-1:0] w_ck_tos;
    logic [CNT_W-1:0] w_ck_cnt;
    logic [CNT_W-1:0] w_ck_cnt_sat;

    assign w_type    = i_firstJTableEntry[2:0];
    assign w_idx     = i_firstJTableEntry[10+IDX_W:11];
    // Extra MSB keeps the range check exact even when SLOTS == 2**IDX_W.
    assign w_bad     = ({1'b0, w_idx} >= C_SLOTS);
    // A restore in the same cycle wins; the concurrent request is dropped.
    assign w_accept  = i_valid & ~i_restore;
    assign w_push    = w_accept & ~w_bad & (w_type == C_T_CALL);
    assign w_pop     = w_accept & ~w_bad & (w_type == C_T_RET) & (r_cnt != '0);
    assign w_miss    = w_accept & ~w_bad & (w_type == C_T_RET) & (r_cnt == '0);
    assign w_ovf     = w_push & (r_cnt == C_DEPTH);
    // Power-of-two depth: natural PTR_W wrap is the modulo.
    assign w_tos_inc = r_tos + PTR_W'(1);

    assign w_ck_tos     = i_ckpt[PTR_W-1:0];
    assign w_ck_cnt     = i_ckpt[PTR_W+CNT_W-1:PTR_W];
    assign w_ck_cnt_sat = (w_ck_cnt > C_DEPTH) ? C_DEPTH : w_ck_cnt;

    assign o_ckpt = {r_cnt, r_tos};

    always_comb begin
        w_slot_addr = '0;
        for (int k = 0; k < SLOTS; k++) begin
            if ({1'b0, w_idx} == (IDX_W+1)'(k)) begin
                w_slot_addr = i_typeAndAddressTableBus[k*ENTRY_W+3 +: XLEN];
            end
        end
    end

    always_comb begin
        w_next_pc = i_seqPc;
        if (!w_bad) begin
            case (w_type)
                C_T_B, C_T_J, C_T_JALR, C_T_CALL: w_next_pc = w_slot_addr;
                C_T_RET: w_next_pc = (r_cnt != '0) ? r_ras[r_tos] : w_slot_addr;
                default: w_next_pc = i_seqPc;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid       <= 1'b0;
            o_nextPc      <= '0;
            o_cutPosition <= '0;
            o_rasMiss     <= 1'b0;
            o_rasOverflow <= 1'b0;
            o_badIdx      <= 1'b0;
            r_tos         <= '0;
            r_cnt         <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else begin
            o_valid       <= w_accept;
            o_rasMiss     <= w_miss;
            o_rasOverflow <= w_ovf;
            o_badIdx      <= w_accept & w_bad;
            if (w_accept) begin
                o_nextPc      <= w_next_pc;
                o_cutPosition <= w_idx;
            end

            if (i_restore) begin
                r_tos <= w_ck_tos;
                r_cnt <= w_ck_cnt_sat;
            end else if (w_push) begin
                r_tos            <= w_tos_inc;
                r_ras[w_tos_inc] <= i_linkPc;
                if (r_cnt != C_DEPTH) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_pop) begin
                r_tos <= r_tos - PTR_W'(1);
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nbj_ras_resolver.sv
`default_nettype none
// ============================================================================
// Module      : tb_nbj_ras_resolver
// Description : Directed self-checking bench for nbj_ras_resolver with a
//               result scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nbj_ras_resolver;

    localparam int XLEN    = 32;
    localparam int SLOTS   = 10;
    localparam int IDX_W   = 8;
    localparam int DEPTH   = 8;
    localparam int ENTRY_W = 3 + XLEN;
    localparam int CKW     = 7;

    localparam logic [2:0] T_NORMAL = 3'd0;
    localparam logic [2:0] T_J      = 3'd2;
    localparam logic [2:0] T_CALL   = 3'd4;
    localparam logic [2:0] T_RET    = 3'd5;
    localparam logic [31:0] SEQ_PC  = 32'h0000_8000;

    logic                     clk;
    logic                     rst_n;
    logic                     valid;
    logic [10+IDX_W:0]        jentry;
    logic [SLOTS*ENTRY_W-1:0] table_bus;
    logic [XLEN-1:0]          seq_pc;
    logic [XLEN-1:0]          link_pc;
    logic                     restore;
    logic [CKW-1:0]           ckpt_in;
    logic                     o_valid;
    logic [XLEN-1:0]          o_next_pc;
    logic [IDX_W-1:0]         o_cut;
    logic                     o_miss;
    logic                     o_ovf;
    logic                     o_bad;
    logic [CKW-1:0]           o_ckpt;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  cut;
        logic        miss;
        logic        ovf;
        logic        bad;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic [CKW-1:0] saved_ckpt;

    nbj_ras_resolver #(
        .XLEN(XLEN), .SLOTS(SLOTS), .IDX_W(IDX_W), .RAS_DEPTH(DEPTH)
    ) dut (
        .i_clk                    (clk),
        .i_rst_n                  (rst_n),
        .i_valid                  (valid),
        .i_firstJTableEntry       (jentry),
        .i_typeAndAddressTableBus (table_bus),
        .i_seqPc                  (seq_pc),
        .i_linkPc                 (link_pc),
        .i_restore                (restore),
        .i_ckpt                   (ckpt_in),
        .o_valid                  (o_valid),
        .o_nextPc                 (o_next_pc),
        .o_cutPosition            (o_cut),
        .o_rasMiss                (o_miss),
        .o_rasOverflow            (o_ovf),
        .o_badIdx                 (o_bad),
        .o_ckpt                   (o_ckpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] slot_addr(input int k);
        if (k == 2)      return 32'h100;
        else if (k == 9) return 32'hABC;
        else             return 32'h4000 + 32'(k) * 32'h10;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Compare whatever the DUT produced this cycle against the scoreboard.
    task automatic check_output(input string tag);
        exp_t e;
        check({tag, ".valid"}, {31'd0, o_valid}, {31'd0, exp_q.size() != 0});
        if (o_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, ".pc"},   o_next_pc,       e.pc);
            check({tag, ".cut"},  {24'd0, o_cut},  {24'd0, e.cut});
            check({tag, ".miss"}, {31'd0, o_miss}, {31'd0, e.miss});
            check({tag, ".ovf"},  {31'd0, o_ovf},  {31'd0, e.ovf});
            check({tag, ".bad"},  {31'd0, o_bad},  {31'd0, e.bad});
        end
        exp_q.delete();
    endtask

    // One request cycle: drive, record expectation, clock, check.
    task automatic req(input string tag, input logic [2:0] t, input int idx,
                       input logic [31:0] link, input logic rs, input logic [CKW-1:0] ck,
                       input logic [31:0] pc, input logic m, input logic ov, input logic bd);
        exp_t e;
        valid   = 1'b1;
        jentry  = '0;
        jentry[2:0] = t;
        jentry[10+IDX_W:11] = IDX_W'(idx);
        link_pc = link;
        restore = rs;
        ckpt_in = ck;
        if (!rs) begin
            e.pc = pc; e.cut = 8'(idx); e.miss = m; e.ovf = ov; e.bad = bd;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        valid   = 1'b0;
        restore = 1'b0;
        check_output(tag);
    endtask

    task automatic do_restore(input logic [CKW-1:0] ck);
        restore = 1'b1;
        ckpt_in = ck;
        @(posedge clk);
        #1;
        restore = 1'b0;
        check_output("restore_only");
    endtask

    initial begin
        rst_n   = 1'b0;
        valid   = 1'b0;
        restore = 1'b0;
        ckpt_in = '0;
        jentry  = '0;
        link_pc = '0;
        seq_pc  = SEQ_PC;
        for (int k = 0; k < SLOTS; k++) begin
            table_bus[k*ENTRY_W +: ENTRY_W] = {slot_addr(k), 3'd0};
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst.valid", {31'd0, o_valid}, 32'd0);
        check("rst.pc", o_next_pc, 32'd0);
        check("rst.flags", {29'd0, o_miss, o_ovf, o_bad}, 32'd0);
        check("rst.ckpt", {25'd0, o_ckpt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // RET on empty stack falls back to slot address.
        req("ret_empty", T_RET, 2, 0, 0, 0, 32'h100, 1, 0, 0);
        check("ret_empty.ckpt", {25'd0, o_ckpt}, 32'd0);

        // Nested CALL/RET on consecutive cycles.
        req("call1", T_CALL, 0, 32'h1004, 0, 0, slot_addr(0), 0, 0, 0);
        req("call2", T_CALL, 0, 32'h2008, 0, 0, slot_addr(0), 0, 0, 0);
        check("call2.ckpt", {25'd0, o_ckpt}, {25'd0, 4'd2, 3'd2});
        req("ret1", T_RET, 1, 0, 0, 0, 32'h2008, 0, 0, 0);
        req("ret2", T_RET, 1, 0, 0, 0, 32'h1004, 0, 0, 0);
        check("nest.ckpt", {25'd0, o_ckpt}, 32'd0);

        // Fill past depth: ninth CALL overwrites the oldest.
        for (int i = 1; i <= 9; i++) begin
            req($sformatf("fill%0d", i), T_CALL, 3, 32'h10 * 32'(i), 0, 0,
                slot_addr(3), 0, (i == 9), 0);
        end
        check("full.ckpt", {25'd0, o_ckpt}, {25'd0, 4'd8, 3'd1});
        for (int i = 9; i >= 2; i--) begin
            req($sformatf("drain%0d", i), T_RET, 4, 0, 0, 0, 32'h10 * 32'(i), 0, 0, 0);
        end
        req("drain_miss", T_RET, 4, 0, 0, 0, slot_addr(4), 1, 0, 0);
        check("drain.ckpt", {25'd0, o_ckpt}, {25'd0, 4'd0, 3'd1});

        // Checkpoint / restore.
        req("ck_call1", T_CALL, 5, 32'hA0, 0, 0, slot_addr(5), 0, 0, 0);
        req("ck_call2", T_CALL, 5, 32'hB0, 0, 0, slot_addr(5), 0, 0, 0);
        saved_ckpt = o_ckpt;
        check("ck.saved", {25'd0, saved_ckpt}, {25'd0, 4'd2, 3'd3});
        req("ck_call3", T_CALL, 5, 32'hC0, 0, 0, slot_addr(5), 0, 0, 0);
        req("ck_ret1", T_RET, 5, 0, 0, 0, 32'hC0, 0, 0, 0);
        req("ck_ret2", T_RET, 5, 0, 0, 0, 32'hB0, 0, 0, 0);
        req("ck_restore_j", T_J, 9, 0, 1, saved_ckpt, 0, 0, 0, 0);
        check("ck.restored", {25'd0, o_ckpt}, {25'd0, 4'd2, 3'd3});
        req("ck_ret_after", T_RET, 5, 0, 0, 0, 32'hB0, 0, 0, 0);

        // Restored count above depth saturates.
        do_restore({4'd15, 3'd5});
        check("sat.ckpt", {25'd0, o_ckpt}, {25'd0, 4'd8, 3'd5});
        do_restore({4'd1, 3'd2});

        // Jump and out-of-range index.
        req("j9", T_J, 9, 0, 0, 0, 32'hABC, 0, 0, 0);
        req("bad_call", T_CALL, 12, 32'hDEAD, 0, 0, SEQ_PC, 0, 0, 1);
        check("bad.ckpt", {25'd0, o_ckpt}, {25'd0, 4'd1, 3'd2});

        // NORMAL and code 7 fall through.
        req("normal", T_NORMAL, 4, 32'hBEEF, 0, 0, SEQ_PC, 0, 0, 0);
        req("type7", 3'd7, 6, 32'hBEEF, 0, 0, SEQ_PC, 0, 0, 0);
        check("normal.ckpt", {25'd0, o_ckpt}, {25'd0, 4'd1, 3'd2});

        // Reset mid-stream discards the in-flight result and empties the stack.
        req("pre_rst_call", T_CALL, 1, 32'h777, 0, 0, slot_addr(1), 0, 0, 0);
        valid = 1'b1;
        jentry = '0;
        jentry[2:0] = T_CALL;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        valid = 1'b0;
        check("mid_rst.valid", {31'd0, o_valid}, 32'd0);
        check("mid_rst.ckpt", {25'd0, o_ckpt}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        req("post_rst_ret", T_RET, 2, 0, 0, 0, 32'h100, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/nbj_ras_resolver.md
# nbj_ras_resolver

Parametrised next-PC resolver for the non-branch-jump path of instruction fetch. It selects the first taken jump slot from the type/address table, produces the redirect PC and cut position, and keeps a circular return address stack (RAS). CALL pushes the link address. RET pops, with underflow fallback. Checkpoint/restore supports mispredict recovery. It replaces the fixed 10-slot, 9-deep, push-only resolver and sits between the jump-table scan and the PC mux.

## Interface
Parameters:
- XLEN, 32, address width
- SLOTS, 10, entries in the type/address table; each entry is 3-bit type (LSBs) + XLEN address = ENTRY_W
- IDX_W, 8, width of the slot index field in the jump-table entry
- RAS_DEPTH, 8, stack entries, power of two ≥ 2; PTR_W = $clog2(RAS_DEPTH), CNT_W = $clog2(RAS_DEPTH+1)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  request valid; one request per cycle, no backpressure
- i_firstJTableEntry  in  11+IDX_W  [2:0] type, [10+IDX_W:11] slot index, [10:3] ignored
- i_typeAndAddressTableBus  in  SLOTS*ENTRY_W  slot k at [k*ENTRY_W +: ENTRY_W], address at +3
- i_seqPc  in  XLEN  fall-through PC
- i_linkPc  in  XLEN  return address pushed on CALL
- i_restore  in  1  load RAS pointer/count from checkpoint
- i_ckpt  in  PTR_W+CNT_W  {count, tos pointer} to restore
- o_valid  out  1  result valid
- o_nextPc  out  XLEN  resolved next PC
- o_cutPosition  out  IDX_W  registered slot index
- o_rasMiss  out  1  RET hit an empty stack
- o_rasOverflow  out  1  CALL overwrote the oldest entry
- o_badIdx  out  1  slot index ≥ SLOTS
- o_ckpt  out  PTR_W+CNT_W  current {count, tos pointer}, combinational from state

## Operation
- Type codes: NORMAL=0, B=1, J=2, JALR=3, CALL=4, RET=5; codes 6 and 7 are treated as NORMAL.
- Slot address = address field of slot `idx`.
- o_badIdx path: idx ≥ SLOTS → nextPc = i_seqPc, o_badIdx=1, no RAS change, whatever the type.
- NORMAL → nextPc = i_seqPc.
- B/J/JALR → nextPc = slot address.
- CALL → nextPc = slot address. Push i_linkPc: tos = tos+1 mod RAS_DEPTH, then entry[tos] = i_linkPc.
  - If count < RAS_DEPTH: count increments.
  - If count == RAS_DEPTH: count stays and o_rasOverflow=1 (oldest entry overwritten).
- RET with count > 0 → nextPc = entry[tos], then tos = tos−1 mod RAS_DEPTH and count decrements.
- RET with count == 0 → nextPc = slot address, o_rasMiss=1, state unchanged.
- i_restore=1 → tos/count ← i_ckpt. Entries are not modified. Any i_valid request in the same cycle is dropped: o_valid=0 next cycle and no push/pop.
- Pointer arithmetic wraps modulo RAS_DEPTH. Count never exceeds RAS_DEPTH. A restored count > RAS_DEPTH saturates to RAS_DEPTH.

## Timing
- All outputs except o_ckpt are registered: request at edge N → result valid after edge N+1 (1-cycle latency).
- o_valid is a single-cycle pulse per accepted request. o_rasMiss, o_rasOverflow and o_badIdx are valid only with o_valid and are 0 otherwise.
- RAS state updates at the same edge that registers the result. A back-to-back request in the next cycle sees the updated stack, e.g. CALL then RET returns the just-pushed value.
- o_ckpt reflects state after the last edge. It is sampled by the consumer alongside the request that should be rewindable.
- Reset (async assert, sync deassert handled upstream): o_valid, o_nextPc, o_cutPosition, o_rasMiss, o_rasOverflow, o_badIdx all 0. tos=0, count=0, all entries 0, so o_ckpt=0.
- Reset mid-stream discards any in-flight result. The first request after deassert sees an empty stack.

## Test plan
- Reset → all outputs 0. Then RET idx=2 with slot2 addr=0x100 → nextPc=0x100, o_rasMiss=1, o_ckpt=0.
- CALL idx=0 with link 0x1004, then CALL with link 0x2008, then RET, then RET on consecutive cycles → nextPc 0x2008 then 0x1004, count ends at 0, no miss.
- 9 CALLs (links 0x10..0x90) with RAS_DEPTH=8 → 9th sets o_rasOverflow=1. 8 RETs return 0x90..0x20. The 9th RET gives o_rasMiss=1.
- Save o_ckpt after 2 CALLs, do 1 CALL + 2 RETs, then i_restore with saved value plus a same-cycle valid J → no o_valid. The next RET returns the 2nd link.
- J idx=9 addr=0xABC → nextPc=0xABC. Then CALL idx=12 with SLOTS=10 → o_badIdx=1, nextPc=i_seqPc, count unchanged.
- NORMAL and type 7 → nextPc=i_seqPc, o_cutPosition = idx, no RAS change.
